// File: rtl/exec_pkg.sv
// exec_pkg -- shared definitions for the instruction execution sequencer:
// state encoding, opcode and ALU operation constants, MFC timeout limit and
// small opcode classification helpers.
package exec_pkg;

    // Execution sequencer states
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DECODE   = 4'd1,
        S_ALU      = 4'd2,
        S_WB       = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_WAIT = 4'd5,
        S_MEM_XFER = 4'd6,
        S_PC_UPD   = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    // Opcodes (IR top nibble); 8..F are undefined and reported as illegal
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LD  = 4'h5;
    localparam logic [3:0] OP_ST  = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;

    // ALU operation select codes
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    // Memory wait timeout: number of MEM_WAIT cycles tolerated without MFC
    localparam int MFC_TIMEOUT = 16;
    localparam int WAIT_CNT_W  = 5;

    // True for the four register-to-register ALU instructions
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    // True for the two instructions that touch memory
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Undefined opcodes occupy the upper half of the opcode space
    function automatic logic is_illegal_op(input logic [3:0] op);
        return op[3];
    endfunction

    // ALU select for an opcode; non-ALU opcodes map to pass-through
    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        logic [2:0] sel;
        sel = ALU_PASS;
        case (op)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            default: sel = ALU_PASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exec_fsm.sv
// exec_fsm -- execute-phase sequencer for a simple CPU datapath.
// Moore FSM: every strobe is decoded from the registered state plus the
// opcode/register fields captured when an instruction is accepted in IDLE.
// Optional feature: define EXEC_MFC_TIMEOUT_EN to abort a memory access that
// sees no MFC within the timeout limit (reported with mem_err alongside done).
module exec_fsm
    import exec_pkg::*;
#(
    parameter int IR_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_active,
    input  logic [IR_W-1:0] IR,
    input  logic            MFC,
    output logic            PC_inc,
    output logic            PC_load,
    output logic            MAR_EN,
    output logic            mem_EN,
    output logic            mem_RW,
    output logic            MDR_EN_read,
    output logic            MDR_EN_write,
    output logic            MDR_out,
    output logic            RF_wr,
    output logic            ALU_out_EN,
    output logic [3:0]      RF_addr,
    output logic [2:0]      ALU_op,
    output logic            done,
    output logic            illegal,
    output logic            mem_err,
    output logic            busy
);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] op_reg;
    logic [3:0] rf_addr_reg;
    logic       start;

    // Operand bits below the register field are not used by the sequencer
    logic unused_ir_low;
    assign unused_ir_low = ^IR[IR_W-9:0];

    // A new instruction is accepted only from IDLE once fetch has finished
    assign start = (state_reg == S_IDLE) && !fetch_active;

`ifdef EXEC_MFC_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0] wait_cnt_reg;
    logic                  err_reg;
    logic                  timeout_hit;

    // Last permitted MEM_WAIT cycle passed with no MFC: abandon the access
    assign timeout_hit = (state_reg == S_MEM_WAIT) && !MFC &&
                         (wait_cnt_reg == WAIT_CNT_W'(MFC_TIMEOUT - 1));
`endif

    // State register, instruction field capture and optional wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            op_reg      <= '0;
            rf_addr_reg <= '0;
`ifdef EXEC_MFC_TIMEOUT_EN
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            // IR is only guaranteed stable while fetch_active is low, so the
            // fields are captured on acceptance and held for the whole run
            if (start) begin
                op_reg      <= IR[IR_W-1 -: 4];
                rf_addr_reg <= IR[IR_W-5 -: 4];
            end
`ifdef EXEC_MFC_TIMEOUT_EN
            // Counter restarts whenever MEM_WAIT is about to be entered
            if (state_reg == S_MEM_ADDR) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == S_MEM_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_W'(1);
            end
            // Remembers why DONE was entered; only looked at while in DONE
            err_reg <= timeout_hit;
`endif
        end
    end

    // Next-state selection and Moore output decode
    always_comb begin
        state_next   = state_reg;
        PC_inc       = 1'b0;
        PC_load      = 1'b0;
        MAR_EN       = 1'b0;
        mem_EN       = 1'b0;
        mem_RW       = 1'b0;
        MDR_EN_read  = 1'b0;
        MDR_EN_write = 1'b0;
        MDR_out      = 1'b0;
        RF_wr        = 1'b0;
        ALU_out_EN   = 1'b0;
        ALU_op       = ALU_PASS;
        done         = 1'b0;
        illegal      = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (!fetch_active) begin
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                if ((op_reg == OP_NOP) || (op_reg == OP_JMP)) begin
                    state_next = S_PC_UPD;
                end else if (is_alu_op(op_reg)) begin
                    state_next = S_ALU;
                end else if (is_mem_op(op_reg)) begin
                    state_next = S_MEM_ADDR;
                end else begin
                    state_next = S_DONE;
                end
            end

            S_ALU: begin
                ALU_out_EN = 1'b1;
                ALU_op     = alu_op_of(op_reg);
                state_next = S_WB;
            end

            S_WB: begin
                RF_wr      = 1'b1;
                state_next = S_PC_UPD;
            end

            S_MEM_ADDR: begin
                MAR_EN       = 1'b1;
                MDR_EN_write = (op_reg == OP_ST);
                state_next   = S_MEM_WAIT;
            end

            S_MEM_WAIT: begin
                mem_EN = 1'b1;
                mem_RW = (op_reg == OP_LD);
                // MFC takes priority over the timeout on the final cycle
                if (MFC) begin
                    state_next = S_MEM_XFER;
                end
`ifdef EXEC_MFC_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = S_DONE;
                end
`endif
            end

            S_MEM_XFER: begin
                if (op_reg == OP_LD) begin
                    MDR_EN_read = 1'b1;
                    MDR_out     = 1'b1;
                    RF_wr       = 1'b1;
                end
                state_next = S_PC_UPD;
            end

            S_PC_UPD: begin
                if (op_reg == OP_JMP) begin
                    PC_load = 1'b1;
                end else begin
                    PC_inc = 1'b1;
                end
                state_next = S_DONE;
            end

            S_DONE: begin
                done       = 1'b1;
                illegal    = is_illegal_op(op_reg);
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != S_IDLE);
    assign RF_addr = rf_addr_reg;

`ifdef EXEC_MFC_TIMEOUT_EN
    assign mem_err = (state_reg == S_DONE) && err_reg;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_exec_fsm.sv
// tb_exec_fsm -- self-checking bench for exec_fsm.
// A queue-based model expands each accepted instruction into its expected
// per-cycle output words; a compare process checks the DUT every cycle.
// Directed runs pin latencies and strobe sets with literal values, then a
// randomized phase exercises fetch handshakes, MFC noise and wait lengths.
// Build with EXEC_MFC_TIMEOUT_EN defined to cover the timeout variant.
`timescale 1ns/1ps
module tb_exec_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_active;
    logic [15:0] IR;
    logic        MFC;
    logic        PC_inc, PC_load, MAR_EN, mem_EN, mem_RW;
    logic        MDR_EN_read, MDR_EN_write, MDR_out, RF_wr, ALU_out_EN;
    logic [3:0]  RF_addr;
    logic [2:0]  ALU_op;
    logic        done, illegal, mem_err, busy;

    int compared   = 0;
    int mismatched = 0;
    int next_n     = 1;

    exec_fsm #(.IR_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_active (fetch_active),
        .IR           (IR),
        .MFC          (MFC),
        .PC_inc       (PC_inc),
        .PC_load      (PC_load),
        .MAR_EN       (MAR_EN),
        .mem_EN       (mem_EN),
        .mem_RW       (mem_RW),
        .MDR_EN_read  (MDR_EN_read),
        .MDR_EN_write (MDR_EN_write),
        .MDR_out      (MDR_out),
        .RF_wr        (RF_wr),
        .ALU_out_EN   (ALU_out_EN),
        .RF_addr      (RF_addr),
        .ALU_op       (ALU_op),
        .done         (done),
        .illegal      (illegal),
        .mem_err      (mem_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

`ifdef EXEC_MFC_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif
    localparam int TMO_LIMIT = 16;

    // Output word layout: {PC_inc,PC_load,MAR_EN,mem_EN,mem_RW,MDR_EN_read,
    // MDR_EN_write,MDR_out,RF_wr,ALU_out_EN,ALU_op[2:0],done,illegal,mem_err,busy}
    localparam logic [16:0] M_PCINC  = 17'h10000;
    localparam logic [16:0] M_PCLOAD = 17'h08000;
    localparam logic [16:0] M_MAR    = 17'h04000;
    localparam logic [16:0] M_MEMEN  = 17'h02000;
    localparam logic [16:0] M_RW     = 17'h01000;
    localparam logic [16:0] M_MDRRD  = 17'h00800;
    localparam logic [16:0] M_MDRWR  = 17'h00400;
    localparam logic [16:0] M_MDROUT = 17'h00200;
    localparam logic [16:0] M_RFWR   = 17'h00100;
    localparam logic [16:0] M_ALUEN  = 17'h00080;
    localparam logic [16:0] M_DONE   = 17'h00008;
    localparam logic [16:0] M_ILL    = 17'h00004;
    localparam logic [16:0] M_ERR    = 17'h00002;
    localparam logic [16:0] M_BUSY   = 17'h00001;

    typedef struct {
        logic [16:0] o;    // expected output word for the cycle
        logic [3:0]  rf;   // expected RF_addr when RF_wr is expected
        bit          w;    // cycle is a memory wait cycle
        bit          lw;   // MFC is returned at the end of this wait cycle
    } ent_t;

    ent_t exp_q[$];

    function automatic logic [16:0] outs();
        return {PC_inc, PC_load, MAR_EN, mem_EN, mem_RW, MDR_EN_read,
                MDR_EN_write, MDR_out, RF_wr, ALU_out_EN, ALU_op,
                done, illegal, mem_err, busy};
    endfunction

    task automatic add(input logic [16:0] o, input logic [3:0] rf, input bit w, input bit lw);
        ent_t e;
        e.o  = o | M_BUSY;
        e.rf = rf;
        e.w  = w;
        e.lw = lw;
        exp_q.push_back(e);
    endtask

    // Expand one instruction into its cycle-by-cycle expected outputs,
    // starting with the decode cycle; n is the memory wait length to emulate
    task automatic push_instr(input logic [15:0] ir, input int n);
        int         op;
        logic [3:0] r;
        int         waits;
        bit         tmo;
        bit         ld;
        op = int'(ir[15:12]);
        r  = ir[11:8];
        add(17'h0, r, 1'b0, 1'b0);
        if (op == 0 || op == 7) begin
            add((op == 7) ? M_PCLOAD : M_PCINC, r, 1'b0, 1'b0);
            add(M_DONE, r, 1'b0, 1'b0);
        end else if (op <= 4) begin
            add(M_ALUEN | (17'(op) << 4), r, 1'b0, 1'b0);
            add(M_RFWR, r, 1'b0, 1'b0);
            add(M_PCINC, r, 1'b0, 1'b0);
            add(M_DONE, r, 1'b0, 1'b0);
        end else if (op <= 6) begin
            ld    = (op == 5);
            add(M_MAR | (ld ? 17'h0 : M_MDRWR), r, 1'b0, 1'b0);
            tmo   = TMO_ON && (n > TMO_LIMIT);
            waits = tmo ? TMO_LIMIT : n;
            for (int k = 1; k <= waits; k++)
                add(M_MEMEN | (ld ? M_RW : 17'h0), r, 1'b1, !tmo && (k == waits));
            if (tmo) begin
                add(M_DONE | M_ERR, r, 1'b0, 1'b0);
            end else begin
                add(ld ? (M_MDRRD | M_MDROUT | M_RFWR) : 17'h0, r, 1'b0, 1'b0);
                add(M_PCINC, r, 1'b0, 1'b0);
                add(M_DONE, r, 1'b0, 1'b0);
            end
        end else begin
            add(M_DONE | M_ILL, r, 1'b0, 1'b0);
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model advance on each rising edge, then compare the settled outputs
    initial begin
        logic [16:0] act;
        logic [16:0] expv;
        logic [3:0]  exp_rf;
        bit          have;
        forever begin
            @(posedge clk);
            if (!rst) begin
                exp_q.delete();
            end else if (exp_q.size() != 0) begin
                exp_q.delete(0);
            end else if (!fetch_active) begin
                push_instr(IR, next_n);
            end
            #1;
            act  = outs();
            have = (exp_q.size() != 0) && rst;
            expv = have ? exp_q[0].o : 17'h0;
            compared++;
            if (act !== expv) begin
                mismatched++;
                $display("FAIL cycle_outputs t=%0t: actual=%05h required=%05h", $time, act, expv);
            end
            if (!rst || (have && exp_q[0].o[8])) begin
                exp_rf = (!rst) ? 4'h0 : exp_q[0].rf;
                compared++;
                if (RF_addr !== exp_rf) begin
                    mismatched++;
                    $display("FAIL cycle_rf_addr t=%0t: actual=%0h required=%0h", $time, RF_addr, exp_rf);
                end
            end
        end
    end

    // Memory responder: MFC only at the planned wait cycle, noise elsewhere
    initial begin
        MFC = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0 && exp_q[0].w)
                MFC = exp_q[0].lw;
            else
                MFC = 1'($urandom_range(0, 1));
        end
    end

    // Run one instruction and pin its latency, wait count and strobe set
    task automatic directed(input string name, input logic [15:0] ir, input int n,
                            input int exp_lat, input int exp_waits,
                            input logic [5:0] exp_flags, input int exp_rf, input int exp_alu);
        int         lat;
        int         waits;
        int         rf_seen;
        int         alu_seen;
        logic [5:0] flags;
        bit         got;
        @(negedge clk);
        IR = ir; next_n = n; fetch_active = 1'b0;
        @(negedge clk);
        fetch_active = 1'b1;
        IR = ~ir;
        lat = 0; waits = 0; flags = '0; rf_seen = -1; alu_seen = -1; got = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            if (c != 0) @(negedge clk);
            lat++;
            if (mem_EN) waits++;
            flags |= {PC_inc, PC_load, RF_wr, MDR_EN_read, illegal, mem_err};
            if (RF_wr) rf_seen = int'(RF_addr);
            if (ALU_out_EN) alu_seen = int'(ALU_op);
            if (done) got = 1'b1;
        end
        chk({name, "_done_seen"}, int'(got), 1);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_wait_cycles"}, waits, exp_waits);
        chk({name, "_strobe_set"}, int'(flags), int'(exp_flags));
        chk({name, "_rf_addr"}, rf_seen, exp_rf);
        chk({name, "_alu_op"}, alu_seen, exp_alu);
    endtask

    initial begin
        int dones;
        int idles;
        rst = 1'b0; fetch_active = 1'b1; IR = 16'h0; next_n = 1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(outs()), 0);
        chk("reset_rf_addr", int'(RF_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("release_idle", int'(outs()), 0);

        // flags order: {PC_inc, PC_load, RF_wr, MDR_EN_read, illegal, mem_err}
        directed("add", 16'h1300, 1, 5, 0, 6'b101000, 3, 1);
        directed("or",  16'h4F00, 1, 5, 0, 6'b101000, 15, 4);
        directed("ld",  16'h5200, 3, 8, 3, 6'b101100, 2, -1);
        directed("st",  16'h6400, 1, 6, 1, 6'b100000, -1, -1);
        directed("jmp", 16'h7000, 1, 3, 0, 6'b010000, -1, -1);
        directed("nop", 16'h0000, 1, 3, 0, 6'b100000, -1, -1);
        directed("ill", 16'hA000, 1, 2, 0, 6'b000010, -1, -1);
`ifdef EXEC_MFC_TIMEOUT_EN
        directed("ld_timeout", 16'h5100, 40, 19, 16, 6'b000001, -1, -1);
`else
        directed("ld_long_wait", 16'h5100, 40, 45, 40, 6'b101100, 1, -1);
`endif

        // Asynchronous reset in the middle of a memory wait
        @(negedge clk);
        IR = 16'h5300; next_n = 10; fetch_active = 1'b0;
        @(negedge clk);
        fetch_active = 1'b1;
        for (int c = 0; c < 20 && !mem_EN; c++) @(negedge clk);
        @(negedge clk);
        chk("pre_reset_mem_wait", int'({busy, mem_EN}), 3);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", int'(outs()), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_rf_addr", int'(RF_addr), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", int'(outs()), 0);

        // Back-to-back NOPs with fetch_active held low
        @(negedge clk);
        IR = 16'h0000; fetch_active = 1'b0;
        dones = 0; idles = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (!busy) idles++;
        end
        fetch_active = 1'b1;
        chk("b2b_done_count", dones, 5);
        chk("b2b_idle_count", idles, 5);

        // Randomized phase
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            fetch_active = 1'($urandom_range(0, 1));
            if (fetch_active) IR = 16'($urandom);
            next_n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 22))
                                                 : int'($urandom_range(1, 6));
        end

        @(negedge clk);
        fetch_active = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: actual=%0d entries left required=0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/exec_fsm.md
EXEC_FSM -- requirements
Module: exec_fsm

Interface
REQ-001 Parameter: IR_W, default 16, instruction register width; opcode is IR[IR_W-1:IR_W-4], register field is IR[IR_W-5:IR_W-8].
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: fetch_active  input  1  high while the fetch FSM is sequencing; low once IR holds a new instruction.
REQ-005 Port: IR  input  IR_W  fetched instruction; stable while fetch_active is low.
REQ-006 Port: MFC  input  1  memory function complete from memory.
REQ-007 Ports: PC_inc, PC_load, MAR_EN, mem_EN, mem_RW (1=read), MDR_EN_read, MDR_EN_write, MDR_out, RF_wr, ALU_out_EN  output  1 each  datapath strobes.
REQ-008 Port: RF_addr  output  4  register-file index, equal to the IR register field.
REQ-009 Port: ALU_op  output  3  000 pass, 001 add, 010 sub, 011 and, 100 or.
REQ-010 Ports: done, illegal, mem_err  output  1 each  one-cycle completion, bad-opcode and memory-timeout pulses.
REQ-011 Port: busy  output  1  high in every state except IDLE.

Function
REQ-012 Moore FSM; all outputs are decoded from the registered state only (RF_addr is registered at DECODE).
REQ-013 States: IDLE, DECODE, ALU, WB, MEM_ADDR, MEM_WAIT, MEM_XFER, PC_UPD, DONE.
REQ-014 IDLE->DECODE when fetch_active samples low; otherwise remain in IDLE.
REQ-015 DECODE dispatch: 0 NOP->PC_UPD; 1-4 ALU ops->ALU; 5 LD, 6 ST->MEM_ADDR; 7 JMP->PC_UPD; 8-F->DONE with illegal=1 in DONE.
REQ-016 ALU: ALU_op per opcode, ALU_out_EN=1; ALU->WB; WB: RF_wr=1; WB->PC_UPD.
REQ-017 MEM_ADDR: MAR_EN=1; ST also asserts MDR_EN_write=1; MEM_ADDR->MEM_WAIT.
REQ-018 MEM_WAIT: mem_EN=1, mem_RW=1 for LD and 0 for ST; hold until MFC=1, then ->MEM_XFER.
REQ-019 MEM_XFER: LD asserts MDR_EN_read=1, MDR_out=1 and RF_wr=1; ST asserts nothing; ->PC_UPD.
REQ-020 PC_UPD: JMP asserts PC_load=1; all other opcodes assert PC_inc=1; ->DONE.
REQ-021 DONE: done=1 for exactly one cycle; ->IDLE unconditionally.
REQ-022 Latencies from DECODE to done, inclusive: NOP/JMP 3, ALU ops 5, illegal 2, LD/ST 5+N where N is the number of MEM_WAIT cycles (N>=1).
REQ-023 MFC high outside MEM_WAIT is ignored.
REQ-024 fetch_active is ignored outside IDLE. After DONE, a new instruction starts only when fetch_active samples low again in IDLE.
REQ-025 All strobes not listed for a state are 0.

Reset
REQ-026 rst low forces IDLE immediately, regardless of clk, including mid-instruction.
REQ-027 While rst is low, every output is 0; RF_addr is 0 and busy is 0.
REQ-028 No datapath write strobe is emitted in the cycle in which rst is deasserted.

Configuration
REQ-029 Macro EXEC_MFC_TIMEOUT_EN, when defined, adds a 5-bit wait counter that clears on entry to MEM_WAIT.
REQ-030 With the macro defined, after 16 MEM_WAIT cycles without MFC the FSM goes to DONE, asserts mem_err=1 with done, and skips PC_UPD.
REQ-031 Without the macro, mem_err is tied 0, MEM_WAIT waits indefinitely and no counter is built.

Structure
REQ-032 Shared package exec_pkg holds the state encoding, opcode constants, ALU_op constants and the timeout limit 16.
REQ-033 The implementation is a single module; the timeout counter is inline and no sub-module is used.

Verification
REQ-034 Reset: rst low mid-MEM_WAIT -> IDLE immediately, all outputs 0, busy=0.
REQ-035 ADD: IR=0x1300, fetch_active falls -> ALU_op=001, then RF_wr with RF_addr=3, then PC_inc, then done, 5 cycles after DECODE.
REQ-036 LD: IR=0x5200, MFC after 3 wait cycles -> MEM_WAIT for 3 cycles, MDR_EN_read/RF_wr in MEM_XFER, done 8 cycles after DECODE.
REQ-037 JMP/illegal: IR=0x7000 -> PC_load=1 and no PC_inc; IR=0xA000 -> illegal=1 with done, no write strobes.
REQ-038 Timeout (macro on): LD with MFC held 0 -> mem_err=1 and done after 16 wait cycles, no PC_inc; macro off -> FSM stays in MEM_WAIT.
REQ-039 Back-to-back: fetch_active held low across DONE -> a second instruction starts on the next IDLE cycle, with exactly one done per instruction.
